// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, flag indices and FSM states for seq_alu
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, one multiplier bit per cycle
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MUL_CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_mcand,
    input  logic [WIDTH-1:0]     i_mplier,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [MUL_CNT_W-1:0] r_cnt;
    logic                 r_busy;

    logic [2*WIDTH-1:0]   w_partial;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 w_last;

    assign w_partial  = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_partial;
    assign w_last     = (r_cnt == MUL_CNT_W'(WIDTH - 1));

    // o_product is the accumulator after the current iteration, so the caller
    // can capture the finished product on the same edge as the last step.
    assign o_done    = r_busy && w_last;
    assign o_product = w_acc_next;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_mcand};
            r_mplier <= i_mplier;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + MUL_CNT_W'(1);
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered WIDTH-bit ALU with NZVC flags and iterative multiply
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MUL_CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inValid,
    output logic             inReady,
    input  logic [2:0]       control,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       aluFlags,
    output logic             outValid
);

    alu_state_t           r_state;
    alu_state_t           w_state_next;
    logic [WIDTH-1:0]     r_result;
    logic [3:0]           r_flags;
    logic                 r_out_valid;

    logic                 w_accept;
    logic                 w_mul_start;
    logic                 w_mul_done;
    logic [2*WIDTH-1:0]   w_mul_prod;
    logic                 w_mul_fin;
    logic                 w_op_fin;

    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_diff;
    logic [WIDTH-1:0]     w_op_res;
    logic                 w_op_c;
    logic                 w_op_v;
    logic [WIDTH-1:0]     w_fin_res;
    logic [3:0]           w_fin_flags;

    assign inReady     = (r_state == ST_IDLE);
    assign w_accept    = inValid && inReady;
    assign w_mul_start = w_accept && (control == OP_MUL);
    assign w_op_fin    = w_accept && (control != OP_MUL);
    assign w_mul_fin   = (r_state == ST_MUL) && w_mul_done;

    assign result   = r_result;
    assign aluFlags = r_flags;
    assign outValid = r_out_valid;

    alu_mul_iter #(
        .WIDTH     (WIDTH),
        .MUL_CNT_W (MUL_CNT_W)
    ) u_mul (
        .clk       (clk),
        .rstN      (rstN),
        .i_start   (w_mul_start),
        .i_mcand   (inputA),
        .i_mplier  (inputB),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    always_comb begin
        w_sum    = {1'b0, inputA} + {1'b0, inputB};
        w_diff   = inputA - inputB;
        w_op_res = '0;
        w_op_c   = 1'b0;
        w_op_v   = 1'b0;
        case (control)
            OP_ADD: begin
                w_op_res = w_sum[WIDTH-1:0];
                w_op_c   = w_sum[WIDTH];
                w_op_v   = (inputA[WIDTH-1] == inputB[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != inputA[WIDTH-1]);
            end
            OP_SUB: begin
                w_op_res = w_diff;
                w_op_c   = (inputA < inputB);
                w_op_v   = (inputA[WIDTH-1] != inputB[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != inputA[WIDTH-1]);
            end
            OP_AND: w_op_res = inputA & inputB;
            OP_OR:  w_op_res = inputA | inputB;
            OP_XOR: w_op_res = inputA ^ inputB;
            OP_SHL: begin
                w_op_res = inputA << 1;
                w_op_c   = inputA[WIDTH-1];
            end
            OP_SHR: begin
                w_op_res = inputA >> 1;
                w_op_c   = inputA[0];
            end
            default: ;
        endcase
    end

    // Completion mux: a multiply finishing and a single-cycle accept are
    // mutually exclusive because accepts only happen in IDLE.
    always_comb begin
        w_fin_flags = '0;
        if (w_mul_fin) begin
            w_fin_res           = w_mul_prod[WIDTH-1:0];
            w_fin_flags[FLAG_C] = (w_mul_prod[2*WIDTH-1:WIDTH] != '0);
            w_fin_flags[FLAG_V] = 1'b0;
        end else begin
            w_fin_res           = w_op_res;
            w_fin_flags[FLAG_C] = w_op_c;
            w_fin_flags[FLAG_V] = w_op_v;
        end
        w_fin_flags[FLAG_N] = w_fin_res[WIDTH-1];
        w_fin_flags[FLAG_Z] = (w_fin_res == '0);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_mul_start) w_state_next = ST_MUL;
            ST_MUL:  if (w_mul_done)  w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state     <= ST_IDLE;
            r_result    <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= w_op_fin || w_mul_fin;
            if (w_op_fin || w_mul_fin) begin
                r_result <= w_fin_res;
                r_flags  <= w_fin_flags;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu against an arithmetic reference model
module tb_seq_alu;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstN;
    logic         inValid;
    logic         inReady;
    logic [2:0]   control;
    logic [W-1:0] inputA;
    logic [W-1:0] inputB;
    logic [W-1:0] result;
    logic [3:0]   aluFlags;
    logic         outValid;

    int checks   = 0;
    int failures = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .inValid  (inValid),
        .inReady  (inReady),
        .control  (control),
        .inputA   (inputA),
        .inputB   (inputB),
        .result   (result),
        .aluFlags (aluFlags),
        .outValid (outValid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {flags[3:0], result[W-1:0]} from signed/unsigned integer arithmetic.
    function automatic logic [W+3:0] model(input logic [2:0] op, input int a, input int b);
        int full, half, r, sa, sb, s;
        logic c, v;
        full = 1 << W;
        half = 1 << (W - 1);
        sa = (a >= half) ? a - full : a;
        sb = (b >= half) ? b - full : b;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (op)
            3'd0: begin r = (a + b) % full; c = (a + b) >= full;
                        s = sa + sb; v = (s >= half) || (s < -half); end
            3'd1: begin r = (a - b + full) % full; c = a < b;
                        s = sa - sb; v = (s >= half) || (s < -half); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin r = (a * 2) % full; c = a >= half; end
            3'd6: begin r = a / 2; c = (a % 2) == 1; end
            default: begin r = (a * b) % full; c = (a * b) >= full; end
        endcase
        model = {c, v, (r == 0), (r >= half), r[W-1:0]};
    endfunction

    task automatic do_op(input logic [2:0] op, input int a, input int b, input bit offer_mid);
        logic [W+3:0] exp;
        exp = model(op, a, b);
        @(negedge clk);
        chk("ready_before_accept", inReady, 1);
        inValid = 1'b1;
        control = op;
        inputA  = W'(a);
        inputB  = W'(b);
        @(posedge clk); #1;
        inValid = 1'b0;
        inputA  = W'($urandom);
        if (op != 3'd7) begin
            chk("single_valid", outValid, 1);
            chk("single_result", result, exp[W-1:0]);
            chk("single_flags", aluFlags, exp[W+3:W]);
        end else begin
            chk("mul_valid_early", outValid, 0);
            chk("mul_ready_low", inReady, 0);
            if (offer_mid) begin
                inValid = 1'b1;
                control = 3'd0;
                inputA  = 8'h01;
                inputB  = 8'h01;
            end
            for (int k = 1; k < W; k++) begin
                @(posedge clk); #1;
                chk("mul_valid_early", outValid, 0);
                chk("mul_ready_low", inReady, 0);
            end
            @(posedge clk); #1;
            inValid = 1'b0;
            chk("mul_valid", outValid, 1);
            chk("mul_result", result, exp[W-1:0]);
            chk("mul_flags", aluFlags, exp[W+3:W]);
            chk("done_ready_low", inReady, 0);
            @(posedge clk); #1;
            chk("after_done_valid", outValid, 0);
            chk("after_done_ready", inReady, 1);
            chk("after_done_result", result, exp[W-1:0]);
            chk("after_done_flags", aluFlags, exp[W+3:W]);
        end
    endtask

    initial begin
        logic [W+3:0] e1, e2;
        int seen;
        rstN    = 1'b0;
        inValid = 1'b0;
        control = 3'd0;
        inputA  = '0;
        inputB  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_result", result, 0);
        chk("reset_flags", aluFlags, 0);
        chk("reset_valid", outValid, 0);
        chk("reset_ready", inReady, 1);
        @(negedge clk);
        rstN = 1'b1;

        do_op(3'd0, 8'h7F, 8'h01, 0);
        chk("add_7f_01_flags", aluFlags, 4'b0101);

        // Back-to-back SUBs on consecutive edges.
        e1 = model(3'd1, 5, 5);
        e2 = model(3'd1, 3, 5);
        @(negedge clk);
        inValid = 1'b1; control = 3'd1; inputA = 8'h05; inputB = 8'h05;
        @(posedge clk); #1;
        inputA = 8'h03;
        chk("b2b_valid1", outValid, 1);
        chk("b2b_result1", result, e1[W-1:0]);
        chk("b2b_flags1", aluFlags, 4'b0010);
        @(posedge clk); #1;
        inValid = 1'b0;
        chk("b2b_valid2", outValid, 1);
        chk("b2b_result2", result, e2[W-1:0]);
        chk("b2b_flags2", aluFlags, 4'b1001);
        @(posedge clk); #1;
        chk("idle_valid", outValid, 0);
        chk("idle_hold_result", result, 8'hFE);

        do_op(3'd6, 8'h01, 8'h55, 0);
        chk("shr_flags", aluFlags, 4'b1010);
        do_op(3'd5, 8'h81, 8'hAA, 0);
        chk("shl_result", result, 8'h02);
        do_op(3'd7, 8'h10, 8'h11, 1);
        chk("mul_10_11_flags", aluFlags, 4'b1000);
        do_op(3'd7, 8'h0F, 8'h0F, 0);
        chk("mul_0f_0f_result", result, 8'hE1);

        for (int i = 0; i < 30; i++) begin
            do_op(3'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
        end

        // Reset in the middle of a multiply.
        do_op(3'd0, 8'h7F, 8'h01, 0);
        @(negedge clk);
        inValid = 1'b1; control = 3'd7; inputA = 8'h0F; inputB = 8'h0F;
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstN = 1'b0;
        @(posedge clk); #1;
        chk("abort_result", result, 0);
        chk("abort_flags", aluFlags, 0);
        chk("abort_valid", outValid, 0);
        chk("abort_ready", inReady, 1);
        @(negedge clk);
        rstN = 1'b1;
        seen = 0;
        repeat (2 * W) begin
            @(posedge clk); #1;
            if (outValid) seen++;
        end
        chk("abort_no_valid", seen, 0);
        chk("abort_hold_result", result, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
